// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipeline run controller: host commands, FSM states, defaults.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_ctrl_pkg;

    // Host command encodings carried on i_cmd
    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11
    } cmd_t;

    // Sequencer states, visible on o_state
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN_FLUSH = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_STEP      = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Fetched word that terminates a RUN
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

    // Enabled cycles granted after a HALT so in-flight instructions retire
    localparam int DEFAULT_DRAIN_CYCLES = 4;

    // Watchdog limit on RUN+DRAIN cycles
    localparam int DEFAULT_MAX_RUN = 2**20;

    // Instruction memory is word-organised; byte address = index << 2
    localparam int WORD_ADDR_SHIFT = 2;

    // States in which the pipeline is allowed to advance
    function automatic logic pipe_active(input state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: accepts N program words and turns each into one instruction-memory write.
// Latency: write strobe/address/data appear the cycle after each word handshake.
// Backpressure: word_ready is high only while words remain in the current LOAD; no stall once armed.
module prog_loader
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       count,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [DATA_WIDTH-1:0] word,
    output logic                  last,
    output logic                  loading,
    output logic [DATA_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] instr
);

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   remain;
    logic              fire;

    assign fire = word_valid & word_ready;
    // The handshake that consumes the final word of this LOAD
    assign last = fire && (remain == {{ADDR_W{1'b0}}, 1'b1});

    // Arm on start, then register one memory write per accepted word; idx wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            word_ready <= 1'b0;
            idx        <= '0;
            remain     <= '0;
            loading    <= 1'b0;
            address    <= '0;
            instr      <= '0;
        end else begin
            loading <= fire;
            if (start) begin
                word_ready <= 1'b1;
                idx        <= '0;
                remain     <= count;
            end else if (fire) begin
                address <= DATA_WIDTH'({idx, {WORD_ADDR_SHIFT{1'b0}}});
                instr   <= word;
                idx     <= idx + 1'b1;
                remain  <= remain - 1'b1;
                if (last) begin
                    word_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run sequencer for the 5-stage MIPS pipeline: LOAD program, RUN to HALT + drain, single STEP.
// Latency: all outputs registered; o_done pulses the cycle after the DONE state.
// Backpressure: o_cmd_ready only in IDLE/RUN, o_word_ready only in LOAD. Option: RUN_CTRL_WATCHDOG_EN.
module pipeline_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_W       = 8,
    parameter int                    DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR   = DATA_WIDTH'(HALT_INSTR_DEFAULT)
`ifdef RUN_CTRL_WATCHDOG_EN
    ,
    parameter int                    MAX_RUN      = DEFAULT_MAX_RUN
`endif
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd,
    input  logic [ADDR_W:0]       i_load_count,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [DATA_WIDTH-1:0] i_fetch_instr,
    output logic                  o_loading,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic                  o_pipe_en,
    output logic                  o_pipe_flush,
    output logic [2:0]            o_state,
    output logic [31:0]           o_cycles,
`ifdef RUN_CTRL_WATCHDOG_EN
    output logic                  o_timeout,
`endif
    output logic                  o_done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             state;
    state_t             nxt;
    cmd_t               cmd;
    logic               cmd_fire;
    logic               load_start;
    logic               load_last;
    logic               drain_last;
    logic               halt_seen;
    logic               wd_hit;
    logic [DRAIN_W-1:0] drain_cnt;

    assign cmd        = cmd_t'(i_cmd);
    assign cmd_fire   = i_cmd_valid & o_cmd_ready;
    assign load_start = (state == ST_IDLE) && cmd_fire && (cmd == CMD_LOAD) && (i_load_count != '0);
    assign drain_last = (drain_cnt == '0);
    // A HALT command and a fetched HALT word in the same cycle collapse into one drain
    assign halt_seen  = (cmd_fire && (cmd == CMD_HALT)) || (i_fetch_instr == HALT_INSTR);
    assign o_state    = state;

    prog_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_loader (
        .clk        (i_clock),
        .rst        (i_reset),
        .start      (load_start),
        .count      (i_load_count),
        .word_valid (i_word_valid),
        .word_ready (o_word_ready),
        .word       (i_word),
        .last       (load_last),
        .loading    (o_loading),
        .address    (o_address),
        .instr      (o_instruccion)
    );

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_RUN) + 1;

    logic [WD_W-1:0] wd_cnt;
    logic            wd_flag;

    // Fires on the MAX_RUN-th enabled cycle of a RUN (drain cycles included)
    assign wd_hit = ((state == ST_RUN) || (state == ST_DRAIN)) && (wd_cnt == WD_W'(MAX_RUN - 1));

    // Count RUN+DRAIN cycles since the flush; report a timeout with o_done and hold it until the next command
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wd_cnt    <= '0;
            wd_flag   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            if (state == ST_RUN_FLUSH) begin
                wd_cnt  <= '0;
                wd_flag <= 1'b0;
            end else if ((state == ST_RUN) || (state == ST_DRAIN)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_hit) begin
                wd_flag <= 1'b1;
            end
            if (cmd_fire) begin
                o_timeout <= 1'b0;
            end else if ((state == ST_DONE) && wd_flag) begin
                o_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Next-state decode; the watchdog has priority over a normal halt
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd)
                        CMD_LOAD: nxt = (i_load_count == '0) ? ST_DONE : ST_LOAD;
                        CMD_RUN:  nxt = ST_RUN_FLUSH;
                        CMD_STEP: nxt = ST_STEP;
                        default:  nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (load_last) begin
                    nxt = ST_DONE;
                end
            end
            ST_RUN_FLUSH: nxt = ST_RUN;
            ST_RUN: begin
                if (wd_hit) begin
                    nxt = ST_DONE;
                end else if (halt_seen) begin
                    nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wd_hit || drain_last) begin
                    nxt = ST_DONE;
                end
            end
            ST_STEP: nxt = ST_DONE;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Sequencer state plus registered outputs decoded from the state being entered
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            o_cmd_ready  <= 1'b0;
            o_pipe_en    <= 1'b0;
            o_pipe_flush <= 1'b0;
            o_done       <= 1'b0;
            o_cycles     <= '0;
            drain_cnt    <= '0;
        end else begin
            state        <= nxt;
            o_cmd_ready  <= (nxt == ST_IDLE) || (nxt == ST_RUN);
            o_pipe_en    <= pipe_active(nxt);
            o_pipe_flush <= (nxt == ST_RUN_FLUSH);
            o_done       <= (state == ST_DONE);

            // o_cycles counts every enabled cycle, restarting at each RUN and saturating
            if (state == ST_RUN_FLUSH) begin
                o_cycles <= '0;
            end else if (o_pipe_en && (o_cycles != '1)) begin
                o_cycles <= o_cycles + 32'd1;
            end

            // Drain counter sits preloaded and only counts down while draining
            if (state != ST_DRAIN) begin
                drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
            end else if (!drain_last) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Self-checking bench for pipeline_run_ctrl: reset, LOAD/RUN/STEP sequences, table and random runs.
// Latency: checks the registered timing of o_loading, o_pipe_en and o_done against cycle stamps.
// Backpressure: drives commands/words only when the matching ready is observed high.
`timescale 1ns/1ps
module tb_pipeline_run_ctrl;
    import mips_ctrl_pkg::*;

    localparam int          DW    = 32;
    localparam int          AW    = 3;
    localparam int          DRAIN = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd;
    logic [AW:0]   i_load_count;
    logic          i_word_valid;
    logic          o_word_ready;
    logic [DW-1:0] i_word;
    logic [DW-1:0] i_fetch_instr;
    logic          o_loading;
    logic [DW-1:0] o_address;
    logic [DW-1:0] o_instruccion;
    logic          o_pipe_en;
    logic          o_pipe_flush;
    logic [2:0]    o_state;
    logic [31:0]   o_cycles;
    logic          o_done;
`ifdef RUN_CTRL_WATCHDOG_EN
    logic          o_timeout;
`endif

    always #5 clk = ~clk;

    pipeline_run_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_W       (AW),
        .DRAIN_CYCLES (DRAIN),
        .HALT_INSTR   (HALT)
`ifdef RUN_CTRL_WATCHDOG_EN
        ,
        .MAX_RUN      (16)
`endif
    ) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd         (i_cmd),
        .i_load_count  (i_load_count),
        .i_word_valid  (i_word_valid),
        .o_word_ready  (o_word_ready),
        .i_word        (i_word),
        .i_fetch_instr (i_fetch_instr),
        .o_loading     (o_loading),
        .o_address     (o_address),
        .o_instruccion (o_instruccion),
        .o_pipe_en     (o_pipe_en),
        .o_pipe_flush  (o_pipe_flush),
        .o_state       (o_state),
        .o_cycles      (o_cycles),
`ifdef RUN_CTRL_WATCHDOG_EN
        .o_timeout     (o_timeout),
`endif
        .o_done        (o_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples 1ns after each rising edge, stamps events with the cycle number
    int          cyc = 0;
    int          en_cnt, en_rise, flush_cnt, done_cnt, done_cyc, timeout_at_done;
    logic        prev_en;
    int          ld_cyc[$];
    logic [31:0] ld_addr[$];
    logic [31:0] ld_data[$];

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (o_pipe_en) begin
            en_cnt++;
            if (!prev_en) en_rise++;
        end
        prev_en = o_pipe_en;
        if (o_pipe_flush) flush_cnt++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_at_done = int'(o_timeout);
`endif
        end
        if (o_loading) begin
            ld_cyc.push_back(cyc);
            ld_addr.push_back(o_address);
            ld_data.push_back(o_instruccion);
        end
    end

    task automatic clear_mon();
        en_cnt = 0; en_rise = 0; flush_cnt = 0; done_cnt = 0; done_cyc = -1;
        timeout_at_done = 0; prev_en = 1'b0;
        ld_cyc.delete(); ld_addr.delete(); ld_data.delete();
    endtask

    function automatic logic [31:0] rand_nop();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0000_0013;
        return v;
    endfunction

    // Issue one command at the next negedge where o_cmd_ready is high; returns the accept cycle
    task automatic send_cmd(input logic [1:0] c, input int n, output int acc);
        int b;
        b = 0;
        while (!o_cmd_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        acc = cyc;
        if (!o_cmd_ready) begin
            check("cmd_ready_wait", o_cmd_ready, 1);
        end else begin
            i_cmd_valid  = 1'b1;
            i_cmd        = c;
            i_load_count = (AW+1)'(n);
            @(negedge clk);
            i_cmd_valid  = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int b;
        b = 0;
        while (!o_word_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!o_word_ready) begin
            check("word_ready_wait", o_word_ready, 1);
        end else begin
            i_word_valid = 1'b1;
            i_word       = w;
            @(negedge clk);
            i_word_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = 0;
        while (done_cnt == 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
    endtask

    // RUN until HALT on the L-th enabled RUN cycle; mode 0 fetch word, 1 HALT cmd, 2 both
    task automatic run_test(input int L, input int mode, input bit noise,
                            input int exp_en, input int exp_cyc);
        int   acc, n, b;
        bit   halted;
        clear_mon();
        send_cmd(CMD_RUN, 0, acc);
        n = 0; b = 0; halted = 1'b0;
        while (!halted && b < 100) begin
            if (o_pipe_en) begin
                n++;
                if (n == L) begin
                    if (mode != 1) i_fetch_instr = HALT;
                    if (mode != 0) begin
                        i_cmd_valid = 1'b1;
                        i_cmd       = CMD_HALT;
                    end
                    halted = 1'b1;
                end else if (noise && $urandom_range(0, 2) == 0 && o_cmd_ready) begin
                    i_cmd_valid  = 1'b1;
                    i_cmd        = 2'($urandom_range(0, 2));
                    i_load_count = (AW+1)'($urandom_range(0, 8));
                end
            end
            @(negedge clk);
            i_cmd_valid   = 1'b0;
            i_fetch_instr = rand_nop();
            b++;
        end
        wait_done(40);
        check("run_pipe_en_cycles", en_cnt, exp_en);
        check("run_pipe_en_contiguous", en_rise, 1);
        check("run_flush_cycles", flush_cnt, 1);
        check("run_o_cycles", o_cycles, exp_cyc);
        check("run_done_pulses", done_cnt, 1);
        check("run_back_to_idle", o_state, ST_IDLE);
    endtask

    typedef struct {
        int run_len;
        int mode;
        int exp_en;
        int exp_cyc;
    } run_vec_t;

    run_vec_t tbl[5];

    initial begin
        int          acc, L, N;
        logic [31:0] w;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];

        tbl[0] = '{10, 0, 14, 14};
        tbl[1] = '{10, 2, 14, 14};
        tbl[2] = '{1,  0, 5,  5};
        tbl[3] = '{4,  1, 8,  8};
        tbl[4] = '{11, 1, 15, 15};

        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = 2'b00; i_load_count = '0;
        i_word_valid = 1'b0; i_word = '0; i_fetch_instr = 32'h0000_0013;
        clear_mon();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state", o_state, ST_IDLE);
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_word_ready", o_word_ready, 0);
        check("rst_loading", o_loading, 0);
        check("rst_address", o_address, 0);
        check("rst_pipe_en", o_pipe_en, 0);
        check("rst_flush", o_pipe_flush, 0);
        check("rst_cycles", o_cycles, 0);
        check("rst_done", o_done, 0);
        i_reset = 1'b0;
        @(negedge clk);

        // Three STEPs with a HALT word on fetch (ignored while stepping)
        clear_mon();
        i_fetch_instr = HALT;
        for (int i = 0; i < 3; i++) send_cmd(CMD_STEP, 0, acc);
        wait_done(10);
        i_fetch_instr = 32'h0000_0013;
        check("step_pipe_en_cycles", en_cnt, 3);
        check("step_isolated_pulses", en_rise, 3);
        check("step_no_flush", flush_cnt, 0);
        check("step_done_pulses", done_cnt, 3);
        check("step_o_cycles", o_cycles, 3);

        // LOAD N=3 back-to-back
        clear_mon();
        send_cmd(CMD_LOAD, 3, acc);
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        send_word(32'hCCCC_0003);
        wait_done(10);
        check("load3_writes", ld_cyc.size(), 3);
        if (ld_cyc.size() == 3) begin
            check("load3_addr0", ld_addr[0], 32'h0);
            check("load3_addr1", ld_addr[1], 32'h4);
            check("load3_addr2", ld_addr[2], 32'h8);
            check("load3_data0", ld_data[0], 32'hAAAA_0001);
            check("load3_data1", ld_data[1], 32'hBBBB_0002);
            check("load3_data2", ld_data[2], 32'hCCCC_0003);
            check("load3_strobe_gap1", ld_cyc[1] - ld_cyc[0], 1);
            check("load3_strobe_gap2", ld_cyc[2] - ld_cyc[1], 1);
            check("load3_done_delay", done_cyc - ld_cyc[2], 1);
        end
        check("load3_done_pulses", done_cnt, 1);

        // LOAD N=0
        clear_mon();
        send_cmd(CMD_LOAD, 0, acc);
        wait_done(10);
        check("load0_writes", ld_cyc.size(), 0);
        check("load0_done_delay", done_cyc - acc, 2);
        check("load0_done_pulses", done_cnt, 1);
        check("load0_idle", o_state, ST_IDLE);

        // HALT in IDLE is a no-op
        clear_mon();
        send_cmd(CMD_HALT, 0, acc);
        repeat (2) @(negedge clk);
        check("halt_idle_state", o_state, ST_IDLE);
        check("halt_idle_no_done", done_cnt, 0);
        check("halt_idle_no_en", en_cnt, 0);
        check("halt_idle_ready", o_cmd_ready, 1);

        // Reset after 2 of 5 words, then LOAD restarts at address 0
        send_cmd(CMD_LOAD, 5, acc);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        i_reset = 1'b1;
        @(negedge clk);
        check("midrst_state", o_state, ST_IDLE);
        check("midrst_word_ready", o_word_ready, 0);
        check("midrst_loading", o_loading, 0);
        check("midrst_cycles", o_cycles, 0);
        i_reset = 1'b0;
        @(negedge clk);
        clear_mon();
        send_cmd(CMD_LOAD, 2, acc);
        send_word(32'h3333_3333);
        send_word(32'h4444_4444);
        wait_done(10);
        check("reload_writes", ld_cyc.size(), 2);
        if (ld_cyc.size() == 2) begin
            check("reload_addr0", ld_addr[0], 32'h0);
            check("reload_addr1", ld_addr[1], 32'h4);
        end

        // Table-driven RUN vectors
        for (int i = 0; i < 5; i++) begin
            run_test(tbl[i].run_len, tbl[i].mode, 1'b0, tbl[i].exp_en, tbl[i].exp_cyc);
        end

        // Random RUNs: model says enabled cycles = halt cycle + drain length
        for (int i = 0; i < 10; i++) begin
            L = $urandom_range(1, 11);
            run_test(L, $urandom_range(0, 2), 1'b1, L + DRAIN, L + DRAIN);
        end

        // Random LOADs with idle gaps between words
        for (int k = 0; k < 6; k++) begin
            N = $urandom_range(1, 2**AW);
            exp_addr.delete();
            exp_data.delete();
            clear_mon();
            send_cmd(CMD_LOAD, N, acc);
            for (int i = 0; i < N; i++) begin
                w = $urandom;
                exp_addr.push_back(32'((i % (2**AW)) * 4));
                exp_data.push_back(w);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_word(w);
            end
            wait_done(10);
            check("rload_writes", ld_cyc.size(), N);
            check("rload_done_pulses", done_cnt, 1);
            check("rload_word_ready_off", o_word_ready, 0);
            for (int i = 0; i < N && i < ld_cyc.size(); i++) begin
                check("rload_addr", ld_addr[i], exp_addr[i]);
                check("rload_data", ld_data[i], exp_data[i]);
            end
        end

`ifdef RUN_CTRL_WATCHDOG_EN
        // Watchdog: RUN with no HALT ends after 16 enabled cycles
        clear_mon();
        send_cmd(CMD_RUN, 0, acc);
        wait_done(60);
        check("wd_pipe_en_cycles", en_cnt, 16);
        check("wd_done_pulses", done_cnt, 1);
        check("wd_timeout_with_done", timeout_at_done, 1);
        check("wd_timeout_held", o_timeout, 1);
        send_cmd(CMD_HALT, 0, acc);
        check("wd_timeout_cleared", o_timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the end, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
